// File: rtl/fifo_burst_rd_if.sv
// Signal bundle between fifo_burst_rd, the FIFO read port and the burst stream consumer.
// master = drain stage side, slave = FIFO/consumer side.
interface fifo_burst_rd_if #(
    parameter int DATA_W = 32,
    parameter int PTR_N  = 5
);
    logic              fifo_empty;
    logic [PTR_N:0]    fifo_level;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        input  fifo_empty, fifo_level, rd_data, m_ready,
        output rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_level, rd_data, m_ready,
        input  rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_rd.sv
// FIFO read-side drain: re-frames FIFO words as valid/ready bursts with a last marker.
// Optional statistics counters are enabled by defining FIFO_BURST_RD_STAT_EN.
module fifo_burst_rd #(
    parameter int DATA_W    = 32,
    parameter int PTR_N     = 5,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64,
    parameter int OBUF_D    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_burst_rd_if.master        io_if,
    output logic                   busy
`ifdef FIFO_BURST_RD_STAT_EN
    ,
    output logic [15:0]            stat_bursts,
    output logic [15:0]            stat_partial
`endif
);
    localparam int LW = PTR_N + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(OBUF_D);
    localparam int OW = $clog2(OBUF_D + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_FLUSH} state_t;

    state_t                        r_state, w_next;
    logic [TW-1:0]                 r_timer;
    logic [LW-1:0]                 r_blen, r_issued, r_capcnt;
    logic                          r_inflight;
    logic [OBUF_D-1:0][DATA_W-1:0] r_buf_data;
    logic [OBUF_D-1:0]             r_buf_last;
    logic [BW-1:0]                 r_wptr, r_rptr;
    logic [OW-1:0]                 r_occ;

    logic w_rd, w_acc, w_pop, w_valid, w_last;
    logic w_start_full, w_start_part, w_level_full, w_room;

    assign w_level_full = io_if.fifo_level >= LW'(BURST_LEN);
    // inflight counts as reserved so the buffer cannot overflow on capture
    assign w_room  = (r_occ + OW'(r_inflight)) < OW'(OBUF_D);
    assign w_acc   = w_rd && !io_if.fifo_empty;
    assign w_valid = (r_occ != '0);
    assign w_last  = w_valid && r_buf_last[r_rptr];
    assign w_pop   = w_valid && io_if.m_ready;

    assign io_if.rd_en   = w_rd;
    assign io_if.m_valid = w_valid;
    assign io_if.m_data  = r_buf_data[r_rptr];
    assign io_if.m_last  = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_start_full = 1'b0;
        w_start_part = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_level_full) begin
                    w_next       = S_BURST;
                    w_start_full = 1'b1;
                end else if (!io_if.fifo_empty) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_level_full) begin
                    w_next       = S_BURST;
                    w_start_full = 1'b1;
                end else if (r_timer == TW'(TIMEOUT - 1) && io_if.fifo_level != '0) begin
                    w_next       = S_BURST;
                    w_start_part = 1'b1;
                end else if (io_if.fifo_empty) begin
                    w_next = S_IDLE;
                end
            end
            S_BURST: if (w_acc && (r_issued + LW'(1) == r_blen)) w_next = S_FLUSH;
            S_FLUSH: if (w_pop && w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd = 1'b0;
        if (r_state == S_BURST)
            w_rd = (r_issued < r_blen) && !io_if.fifo_empty && w_room;
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer    <= '0;
            r_blen     <= '0;
            r_issued   <= '0;
            r_capcnt   <= '0;
            r_inflight <= 1'b0;
            r_buf_data <= '0;
            r_buf_last <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
        end else begin
            if (r_state == S_WAIT) begin
                if (r_timer != TW'(TIMEOUT - 1)) r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end

            if (w_start_full)      r_blen <= LW'(BURST_LEN);
            else if (w_start_part) r_blen <= io_if.fifo_level;

            if (w_start_full || w_start_part) begin
                r_issued <= '0;
                r_capcnt <= '0;
            end else begin
                if (w_acc)      r_issued <= r_issued + LW'(1);
                if (r_inflight) r_capcnt <= r_capcnt + LW'(1);
            end

            r_inflight <= w_acc;

            // RAM data is valid exactly one cycle after the accepted read
            if (r_inflight) begin
                r_buf_data[r_wptr] <= io_if.rd_data;
                r_buf_last[r_wptr] <= (r_capcnt + LW'(1) == r_blen);
                r_wptr <= (r_wptr == BW'(OBUF_D - 1)) ? '0 : r_wptr + BW'(1);
            end

            if (w_pop) r_rptr <= (r_rptr == BW'(OBUF_D - 1)) ? '0 : r_rptr + BW'(1);

            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef FIFO_BURST_RD_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bursts  <= '0;
            stat_partial <= '0;
        end else begin
            if (w_pop && w_last) stat_bursts  <= stat_bursts + 16'd1;
            if (w_start_part)    stat_partial <= stat_partial + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_rd.sv
// Bench for fifo_burst_rd: queue-based FIFO model feeds the DUT, a scoreboard checks the stream.
module tb_fifo_burst_rd;
    localparam int DATA_W = 32, PTR_N = 5, BURST_LEN = 8, TIMEOUT = 64, OBUF_D = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    fifo_burst_rd_if #(.DATA_W(DATA_W), .PTR_N(PTR_N)) bus ();
`ifdef FIFO_BURST_RD_STAT_EN
    logic [15:0] stat_bursts, stat_partial;
`endif

    fifo_burst_rd #(.DATA_W(DATA_W), .PTR_N(PTR_N), .BURST_LEN(BURST_LEN),
                    .TIMEOUT(TIMEOUT), .OBUF_D(OBUF_D)) dut (
        .clk(clk), .rst(rst), .io_if(bus), .busy(busy)
`ifdef FIFO_BURST_RD_STAT_EN
        , .stat_bursts(stat_bursts), .stat_partial(stat_partial)
`endif
    );

    int checks = 0, failures = 0;
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W:0]   exp_q[$];
    int n_rd, n_pop, n_last, beat_cnt, cur_blen, cyc_n, rdy_mode, pushed, topup_limit;
    bit force_empty;
    bit acc_s, mv_s, busy_s, hs_last_s, rd_s;
    logic [DATA_W-1:0] seq = 32'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(seq);
            seq = seq + 32'h9e37;
            pushed++;
        end
    endtask

    task automatic drive();
        int lvl;
        lvl = fifo_q.size();
        if (lvl > 32) lvl = 32;
        bus.fifo_empty = force_empty || (fifo_q.size() == 0);
        bus.fifo_level = lvl[PTR_N:0];
        case (rdy_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = ($urandom_range(0, 1) == 1);
        endcase
    endtask

    // One clock: sample at negedge, then act as FIFO RAM just after posedge.
    task automatic cyc();
        logic [DATA_W-1:0] w;
        @(negedge clk);
        rd_s      = bus.rd_en;
        acc_s     = bus.rd_en && !bus.fifo_empty;
        mv_s      = bus.m_valid;
        busy_s    = busy;
        hs_last_s = bus.m_valid && bus.m_ready && bus.m_last;
        cyc_n++;
        @(posedge clk);
        #1;
        if (acc_s) begin
            w = fifo_q.pop_front();
            bus.rd_data = w;
            beat_cnt++;
            exp_q.push_back({(beat_cnt == cur_blen), w});
            if (beat_cnt == cur_blen) beat_cnt = 0;
            n_rd++;
        end else begin
            bus.rd_data = $urandom;
        end
        while (fifo_q.size() < 16 && pushed < topup_limit) push_words(1);
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        n_rd = 0; n_pop = 0; n_last = 0; beat_cnt = 0;
        pushed = 0; topup_limit = 0; force_empty = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: every handshake must match the next word read, in order, with the right last tag.
    bit               held_v;
    logic [DATA_W-1:0] held_d;
    logic             held_l;
    logic [DATA_W:0]  e;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", bus.m_valid, 1);
                chk("hold_data", bus.m_data, held_d);
                chk("hold_last", bus.m_last, held_l);
            end
            chk("occ_bound", (n_rd - n_pop) <= OBUF_D, 1);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.m_data, e[DATA_W-1:0]);
                    chk("beat_last", bus.m_last, e[DATA_W]);
                end
                n_pop++;
                if (bus.m_last) n_last++;
            end
            held_v = bus.m_valid && !bus.m_ready;
            held_d = bus.m_data;
            held_l = bus.m_last;
        end
    end

    initial begin
        int c0, first_acc, first_mv, last_hs, gap, n;
        bit gap_done;
        rst = 1'b1;
        rdy_mode = 0; cur_blen = BURST_LEN; cyc_n = 0;
        bus.rd_data = '0;
        force_empty = 1'b0;
        drive();
        #1;
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_busy", busy, 0);
`ifdef FIFO_BURST_RD_STAT_EN
        chk("rst_stats", {stat_bursts, stat_partial}, 0);
`endif

        // 1: full burst, ready held high
        do_reset();
        cur_blen = 8; rdy_mode = 1;
        push_words(10); drive();
        c0 = cyc_n; first_acc = -1; first_mv = -1; last_hs = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (acc_s && first_acc < 0) first_acc = cyc_n;
            if (mv_s && first_mv < 0) first_mv = cyc_n;
            if (hs_last_s && last_hs < 0) begin
                last_hs = cyc_n;
                chk("t1_busy_at_last", busy_s, 1);
            end else if (last_hs >= 0 && cyc_n == last_hs + 1) begin
                chk("t1_busy_after_last", busy_s, 0);
            end
        end
        chk("t1_first_rd_cyc", first_acc - c0, 2);
        chk("t1_latency", first_mv - first_acc, 2);
        chk("t1_last_cyc", last_hs - c0, 11);
        chk("t1_reads", n_rd, 8);
        chk("t1_beats", n_pop, 8);
        chk("t1_lasts", n_last, 1);

        // 2: partial burst after timeout
        do_reset();
        cur_blen = 3; rdy_mode = 1;
        push_words(3); drive();
        c0 = cyc_n; first_acc = -1; n = 0;
        while (first_acc < 0 && n < 200) begin
            cyc(); n++;
            if (acc_s) first_acc = cyc_n;
        end
        chk("t2_wait_cycles", first_acc - c0, 66);
        n = 0;
        while (n_pop < 3 && n < 50) begin cyc(); n++; end
        repeat (3) cyc();
        chk("t2_reads", n_rd, 3);
        chk("t2_beats", n_pop, 3);
        chk("t2_lasts", n_last, 1);
`ifdef FIFO_BURST_RD_STAT_EN
        chk("t2_stat_partial", stat_partial, 1);
        chk("t2_stat_bursts", stat_bursts, 1);
`endif

        // 3: consumer stalled, buffer fills then drains
        do_reset();
        cur_blen = 8; rdy_mode = 0;
        push_words(8); drive();
        repeat (20) cyc();
        chk("t3_reads_stalled", n_rd, OBUF_D);
        chk("t3_rd_en_stalled", rd_s, 0);
        chk("t3_no_beats", n_pop, 0);
        rdy_mode = 1; drive();
        n = 0;
        while (n_pop < 8 && n < 60) begin cyc(); n++; end
        repeat (3) cyc();
        chk("t3_beats", n_pop, 8);
        chk("t3_reads", n_rd, 8);
        chk("t3_scoreboard_empty", exp_q.size(), 0);

        // 4: FIFO goes empty (stale level) after beat 4
        do_reset();
        cur_blen = 8; rdy_mode = 1;
        push_words(8); drive();
        gap = 0; gap_done = 1'b0; n = 0;
        while (n_pop < 8 && n < 100) begin
            cyc(); n++;
            if (gap > 0) begin
                chk("t4_gap_rd_en", rd_s, 0);
                gap--;
                if (gap == 0) begin force_empty = 1'b0; drive(); end
            end else if (n_rd == 4 && !gap_done) begin
                gap_done = 1'b1; gap = 5; force_empty = 1'b1; drive();
            end
        end
        chk("t4_gap_seen", gap_done, 1);
        chk("t4_beats", n_pop, 8);
        chk("t4_lasts", n_last, 1);

        // 5: async reset with two beats buffered
        do_reset();
        cur_blen = 8; rdy_mode = 0;
        push_words(8); drive();
        n = 0;
        while (n_rd < 2 && n < 20) begin cyc(); n++; end
        force_empty = 1'b1; drive();
        repeat (2) cyc();
        chk("t5_buffered_valid", mv_s, 1);
        chk("t5_buffered_reads", n_rd, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_m_valid", bus.m_valid, 0);
        chk("t5_rst_rd_en", bus.rd_en, 0);
        chk("t5_rst_busy", busy, 0);
        do_reset();
        cur_blen = 8; rdy_mode = 1;
        push_words(8); drive();
        n = 0;
        while (n_pop < 8 && n < 60) begin cyc(); n++; end
        repeat (5) cyc();
        chk("t5_beats_after", n_pop, 8);
        chk("t5_lasts_after", n_last, 1);

        // 6: random backpressure, back-to-back full bursts
        do_reset();
        cur_blen = 8; rdy_mode = 2; topup_limit = 1000;
        push_words(16); drive();
        n = 0;
        while (n_pop < 1000 && n < 20000) begin cyc(); n++; end
        repeat (3) cyc();
        chk("t6_beats", n_pop, 1000);
        chk("t6_reads", n_rd, 1000);
        chk("t6_lasts", n_last, 125);
        chk("t6_scoreboard_empty", exp_q.size(), 0);
`ifdef FIFO_BURST_RD_STAT_EN
        chk("t6_stat_bursts", stat_bursts, 125);
        chk("t6_stat_partial", stat_partial, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_burst_rd.md
Name: fifo_burst_rd

Overview:
Read-side drain stage downstream of the FIFO pointer controller, in the read clock domain. Watches the FIFO empty flag and fill level, issues read enables to the FIFO, and captures the 1-cycle-latency RAM read data. Re-frames the FIFO contents as a valid/ready burst stream with a last-beat marker. Bursts start at a full BURST_LEN, or at a shorter partial length when data has waited TIMEOUT cycles.

Parameters:
DATA_W, 32, data word width
PTR_N, 5, FIFO pointer bits; the fill level input is PTR_N+1 bits
BURST_LEN, 8, maximum beats per burst; must satisfy 1 <= BURST_LEN <= 2^PTR_N
TIMEOUT, 64, cycles a partial amount of data waits before a partial burst is forced; minimum 2
OBUF_D, 4, output skid buffer depth; minimum 2

Ports:
clk  in  1  read-domain clock
rst  in  1  reset; asynchronous assert, active-high
fifo_empty  in  1  FIFO empty flag, read domain
fifo_level  in  PTR_N+1  FIFO fill level, read domain; may lag the true level (pessimistic)
rd_en  out  1  read request to the FIFO; a read is accepted when rd_en && !fifo_empty
rd_data  in  DATA_W  RAM read data, valid the cycle after an accepted read
m_valid  out  1  stream data valid
m_ready  in  1  stream consumer ready
m_data  out  DATA_W  stream data
m_last  out  1  final beat of the current burst
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking/reset: single clock clk. Asynchronous, active-high reset rst.
- Reset values: rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0. State=IDLE, all counters 0, output buffer empty.
- Reset mid-burst: in-flight read data and buffered beats are discarded. No m_last is emitted for the aborted burst.
- States: IDLE, WAIT, BURST, FLUSH.
- IDLE:
  - fifo_level >= BURST_LEN: go to BURST, latch blen=BURST_LEN.
  - Otherwise, !fifo_empty: go to WAIT, timer=0.
- WAIT: timer increments every cycle.
  - fifo_level >= BURST_LEN: go to BURST, blen=BURST_LEN.
  - Otherwise, timer==TIMEOUT-1 and fifo_level != 0: go to BURST, blen=fifo_level.
  - fifo_empty: go to IDLE.
- BURST:
  - rd_en = (issued < blen) && !fifo_empty && (occ + inflight < OBUF_D).
  - occ is output buffer occupancy; inflight is the number of accepted reads whose data has not yet been captured (0 or 1).
  - issued increments on each accepted read.
  - When issued reaches blen, rd_en drops the same cycle and the state goes to FLUSH.
- FLUSH: rd_en=0. Go to IDLE on the handshake m_valid && m_ready && m_last.
- Capture: the cycle after an accepted read, rd_data is written to the output buffer. The tag last=1 is set when it is beat number blen of the burst.
- Output: m_valid, m_data and m_last are driven from the head entry of the output buffer. They are registered, with no combinational path from m_ready.
  - The head advances on m_valid && m_ready.
  - m_data and m_last hold stable while m_valid && !m_ready.
- Throughput: 1 beat/cycle sustained when m_ready=1 and the FIFO is non-empty.
- Latency: first accepted read to m_valid is 2 cycles (1 cycle RAM latency + 1 cycle capture register).
- Buffer full: rd_en stalls. The buffer never overflows, and reads are never dropped.
- fifo_empty rising mid-BURST (level was stale): rd_en stalls with no timeout and no early m_last. The burst resumes when data arrives.
- Simultaneous capture and pop: occupancy is unchanged.
- Counter widths: issued and blen are PTR_N+1 bits. timer is $clog2(TIMEOUT) bits and saturates.

Optional Feature:
Macro FIFO_BURST_RD_STAT_EN.
- Defined: adds output ports stat_bursts (16 bits) and stat_partial (16 bits).
  - stat_bursts counts completed bursts, incrementing on the m_last handshake.
  - stat_partial counts bursts that started from the WAIT timeout with blen < BURST_LEN.
  - Both counters wrap at 2^16, reset to 0, and update one cycle after the event.
- Undefined: neither port exists and no counter logic is present. All other behaviour is identical.

Test Plan:
1. Reset, then fifo_level=8, fifo_empty=0, m_ready=1 held → rd_en high for exactly 8 accepted reads. 8 beats are emitted with data matching the read order. m_last is set only on beat 8. busy returns to 0 one cycle after the last handshake.
2. fifo_level=3 steady, TIMEOUT=64 → WAIT for 64 cycles, then a 3-beat burst with m_last on beat 3. stat_partial=1 when FIFO_BURST_RD_STAT_EN is defined.
3. Full burst with m_ready=0 → at most OBUF_D=4 accepted reads, then rd_en=0. m_data and m_last hold stable. Releasing m_ready drains all 8 beats in order with no loss and no duplication.
4. fifo_empty asserted for 5 cycles after beat 4 of a BURST_LEN=8 burst → rd_en=0 during the gap, no early m_last. The burst completes with 8 beats total.
5. rst asserted asynchronously mid-burst with 2 beats buffered → m_valid=0 and rd_en=0 immediately, state IDLE. After release, the next burst starts clean with a correct beat count.
6. Random m_ready toggling over 1000 beats, with fifo_level back-to-back at 8 or more → the output sequence equals the input sequence. Every 8th beat carries m_last.
